// File: rtl/timer_seq_ctrl.sv
// APB master sequencer that programs and services an 8-bit APB timer in periodic mode.
// Optional ACCESS-phase timeout: define TIMER_SEQ_TIMEOUT_EN.
module timer_seq_ctrl #(
  parameter int POLL_CYCLES    = 32,
  parameter bit AUTO_RELOAD    = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] cfg_reload,
  input  logic       cfg_dw,
  input  logic [1:0] cfg_cks,
  output logic       busy,
  output logic       tick,
  output logic [7:0] tick_cnt,
  output logic       err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  // state   | meaning
  // IDLE    | no sequence active
  // W_TDR   | write reload value to TDR
  // W_LD    | write TCR with load bit set
  // W_RUN   | write TCR with enable bit set
  // WAIT    | idle poll interval between TSR reads
  // R_TSR   | read TSR, check expiry flag
  // W_CLR   | clear TSR
  // S_TCR   | shutdown: disable timer
  // S_TSR   | shutdown: clear TSR
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_W_TDR = 4'd1;
  localparam logic [3:0] ST_W_LD  = 4'd2;
  localparam logic [3:0] ST_W_RUN = 4'd3;
  localparam logic [3:0] ST_WAIT  = 4'd4;
  localparam logic [3:0] ST_R_TSR = 4'd5;
  localparam logic [3:0] ST_W_CLR = 4'd6;
  localparam logic [3:0] ST_S_TCR = 4'd7;
  localparam logic [3:0] ST_S_TSR = 4'd8;

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  logic [3:0]    state;
  logic          acc;
  logic          stop_pend;
  logic          dw_q;
  logic [1:0]    cks_q;
  logic [7:0]    reload_q;
  logic [PW-1:0] poll_cnt;
  logic          xfer_st;
  logic          stop_req;
  logic          expiry;
  logic          timeout;
  logic [3:0]    succ;
  logic          unused_prdata;

  assign stop_req      = stop_pend | stop;
  assign expiry        = dw_q ? prdata[1] : prdata[0];
  assign unused_prdata = ^prdata[7:2];
  assign busy          = (state != ST_IDLE);
  assign psel          = xfer_st;
  assign penable       = acc;

  always_comb begin
    xfer_st = 1'b1;
    paddr   = 8'h00;
    pwrite  = 1'b1;
    pwdata  = 8'h00;
    case (state)
      ST_W_TDR: pwdata = reload_q;
      ST_W_LD: begin
        paddr  = 8'h01;
        pwdata = {1'b1, 1'b0, dw_q, 1'b0, 2'b00, cks_q};
      end
      ST_W_RUN: begin
        paddr  = 8'h01;
        pwdata = {1'b0, 1'b0, dw_q, 1'b1, 2'b00, cks_q};
      end
      ST_R_TSR: begin
        paddr  = 8'h02;
        pwrite = 1'b0;
      end
      ST_W_CLR: paddr = 8'h02;
      ST_S_TCR: paddr = 8'h01;
      ST_S_TSR: paddr = 8'h02;
      default: begin
        xfer_st = 1'b0;
        pwrite  = 1'b0;
      end
    endcase
  end

  // Successor on a clean transfer completion; a pending stop diverts to shutdown.
  always_comb begin
    succ = ST_IDLE;
    case (state)
      ST_W_TDR: succ = ST_W_LD;
      ST_W_LD:  succ = ST_W_RUN;
      ST_W_RUN: succ = ST_WAIT;
      ST_R_TSR: succ = expiry ? ST_W_CLR : ST_WAIT;
      ST_W_CLR: succ = AUTO_RELOAD ? ST_W_LD : ST_WAIT;
      ST_S_TCR: succ = ST_S_TSR;
      default:  succ = ST_IDLE;
    endcase
    if (stop_req && state != ST_S_TCR && state != ST_S_TSR)
      succ = ST_S_TCR;
  end

`ifdef TIMER_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      to_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (acc && !pready && to_cnt != '0)
      to_cnt <= to_cnt - 1'b1;
    else if (!(acc && !pready))
      to_cnt <= TW'(TIMEOUT_CYCLES - 1);
  end

  assign timeout = acc && !pready && (to_cnt == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      acc       <= 1'b0;
      stop_pend <= 1'b0;
      dw_q      <= 1'b0;
      cks_q     <= 2'b00;
      reload_q  <= 8'h00;
      poll_cnt  <= '0;
      tick      <= 1'b0;
      tick_cnt  <= 8'h00;
      err       <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (stop && state != ST_IDLE)
        stop_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          acc <= 1'b0;
          if (start && !stop) begin
            reload_q  <= cfg_reload;
            dw_q      <= cfg_dw;
            cks_q     <= cfg_cks;
            err       <= 1'b0;
            stop_pend <= 1'b0;
            state     <= ST_W_TDR;
          end
        end
        ST_WAIT: begin
          if (stop_req)
            state <= ST_S_TCR;
          else if (poll_cnt == '0)
            state <= ST_R_TSR;
          else
            poll_cnt <= poll_cnt - 1'b1;
        end
        ST_W_TDR, ST_W_LD, ST_W_RUN, ST_R_TSR, ST_W_CLR, ST_S_TCR, ST_S_TSR: begin
          if (!acc) begin
            acc <= 1'b1;
          end else if (timeout) begin
            acc       <= 1'b0;
            err       <= 1'b1;
            stop_pend <= 1'b0;
            state     <= ST_IDLE;
          end else if (pready) begin
            acc <= 1'b0;
            if (pslverr) begin
              err       <= 1'b1;
              stop_pend <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              state <= succ;
              if (succ == ST_WAIT)
                poll_cnt <= PW'(POLL_CYCLES - 1);
              if (succ == ST_IDLE)
                stop_pend <= 1'b0;
              if (state == ST_R_TSR && expiry) begin
                tick     <= 1'b1;
                tick_cnt <= tick_cnt + 8'd1;
              end
            end
          end
        end
        default: begin
          acc   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl acting as the APB slave (timer) side.
module tb_timer_seq_ctrl;
  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic [7:0] cfg_reload = 8'h00;
  logic       cfg_dw = 1'b0;
  logic [1:0] cfg_cks = 2'b00;
  logic       busy, tick, err, psel, penable, pwrite;
  logic [7:0] tick_cnt, paddr, pwdata;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b1, pslverr = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  timer_seq_ctrl #(.POLL_CYCLES(4), .AUTO_RELOAD(1'b1), .TIMEOUT_CYCLES(2)) dut (
    .pclk(pclk), .presetn(presetn), .start(start), .stop(stop),
    .cfg_reload(cfg_reload), .cfg_dw(cfg_dw), .cfg_cks(cfg_cks),
    .busy(busy), .tick(tick), .tick_cnt(tick_cnt), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_setup(input string tag);
    int n = 0;
    while (psel !== 1'b1 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk({tag, " setup psel"}, {31'b0, psel}, 32'd1);
    chk({tag, " setup penable"}, {31'b0, penable}, 32'd0);
  endtask

  // Serves one transfer: checks SETUP, holds pready low for 'waits' ACCESS cycles,
  // ends on the negedge after completion.
  task automatic xfer(input string tag, input logic [7:0] a, input logic w, input logic [7:0] d,
                      input logic [7:0] rd, input int waits, input logic serr, input logic stop_acc);
    wait_setup(tag);
    chk({tag, " paddr"}, {24'b0, paddr}, {24'b0, a});
    chk({tag, " pwrite"}, {31'b0, pwrite}, {31'b0, w});
    chk({tag, " pwdata"}, {24'b0, pwdata}, {24'b0, d});
    for (int k = 1; k <= waits + 1; k++) begin
      @(negedge pclk);
      stop = (k == 1) && stop_acc;
      chk({tag, " access penable"}, {31'b0, penable}, 32'd1);
      chk({tag, " access paddr"}, {24'b0, paddr}, {24'b0, a});
      chk({tag, " access pwdata"}, {24'b0, pwdata}, {24'b0, d});
      pready  = (k == waits + 1);
      pslverr = serr && (k == waits + 1);
      prdata  = rd;
    end
    @(negedge pclk);
    pready = 1'b1; pslverr = 1'b0; prdata = 8'h00; stop = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] rl, input logic dw, input logic [1:0] cks);
    cfg_reload = rl; cfg_dw = dw; cfg_cks = cks;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  initial begin
    @(negedge pclk);
    @(negedge pclk);
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset tick", {31'b0, tick}, 0);
    chk("reset tick_cnt", {24'b0, tick_cnt}, 0);
    chk("reset err", {31'b0, err}, 0);
    chk("reset psel", {31'b0, psel}, 0);
    chk("reset penable", {31'b0, penable}, 0);
    chk("reset paddr", {24'b0, paddr}, 0);
    chk("reset pwdata", {24'b0, pwdata}, 0);
    presetn = 1'b1;
    @(negedge pclk);

    // Count-up sequence
    pulse_start(8'hF0, 1'b0, 2'b00);
    chk("start busy", {31'b0, busy}, 1);
    xfer("w_tdr", 8'h00, 1, 8'hF0, 0, 0, 0, 0);
    xfer("w_ld", 8'h01, 1, 8'h80, 0, 0, 0, 0);
    xfer("w_run", 8'h01, 1, 8'h10, 0, 0, 0, 0);
    chk("wait psel low", {31'b0, psel}, 0);
    xfer("r_tsr0", 8'h02, 0, 8'h00, 8'h00, 0, 0, 0);
    chk("no ovf tick", {31'b0, tick}, 0);
    xfer("r_tsr1", 8'h02, 0, 8'h00, 8'h01, 0, 0, 0);
    chk("ovf tick", {31'b0, tick}, 1);
    chk("ovf tick_cnt", {24'b0, tick_cnt}, 1);
    xfer("w_clr", 8'h02, 1, 8'h00, 0, 0, 0, 0);
    xfer("reload ld", 8'h01, 1, 8'h80, 0, 0, 0, 0);
    xfer("reload run", 8'h01, 1, 8'h10, 0, 0, 0, 0);
    xfer("r_tsr2", 8'h02, 0, 8'h00, 8'h00, 0, 0, 0);
    chk("tick after clear", {31'b0, tick}, 0);

    // Stop during WAIT
    stop = 1'b1;
    @(negedge pclk);
    stop = 1'b0;
    xfer("s_tcr", 8'h01, 1, 8'h00, 0, 0, 0, 0);
    xfer("s_tsr", 8'h02, 1, 8'h00, 0, 0, 0, 0);
    chk("stop busy", {31'b0, busy}, 0);
    chk("stop psel", {31'b0, psel}, 0);

    // Simultaneous start+stop in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    @(negedge pclk);
    start = 1'b0; stop = 1'b0;
    chk("start+stop idle", {31'b0, busy}, 0);

    // Count-down sequence
    pulse_start(8'h00, 1'b1, 2'b11);
    xfer("dn w_tdr", 8'h00, 1, 8'h00, 0, 0, 0, 0);
    xfer("dn w_ld", 8'h01, 1, 8'hA3, 0, 0, 0, 0);
    xfer("dn w_run", 8'h01, 1, 8'h33, 0, 0, 0, 0);
    pulse_start(8'h55, 1'b0, 2'b00);
    xfer("dn r_ovf", 8'h02, 0, 8'h00, 8'h01, 0, 0, 0);
    chk("dn ovf no tick", {31'b0, tick}, 0);
    chk("dn ovf cnt", {24'b0, tick_cnt}, 1);
    xfer("dn r_udf", 8'h02, 0, 8'h00, 8'h02, 0, 0, 0);
    chk("dn udf tick", {31'b0, tick}, 1);
    chk("dn udf cnt", {24'b0, tick_cnt}, 2);
    xfer("dn w_clr", 8'h02, 1, 8'h00, 0, 0, 0, 0);
`ifdef TIMER_SEQ_TIMEOUT_EN
    wait_setup("to w_ld");
    chk("to paddr", {24'b0, paddr}, 32'h01);
    chk("to pwdata", {24'b0, pwdata}, 32'hA3);
    pready = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    @(negedge pclk);
    pready = 1'b1;
    chk("to err", {31'b0, err}, 1);
    chk("to busy", {31'b0, busy}, 0);
    chk("to psel", {31'b0, psel}, 0);
    pulse_start(8'h00, 1'b1, 2'b11);
    chk("to restart err", {31'b0, err}, 0);
    xfer("to w_tdr", 8'h00, 1, 8'h00, 0, 0, 0, 0);
    xfer("to w_ld2", 8'h01, 1, 8'hA3, 0, 0, 0, 0);
`else
    xfer("dn w_ld wait", 8'h01, 1, 8'hA3, 0, 3, 0, 0);
`endif
    xfer("dn w_run2", 8'h01, 1, 8'h33, 0, 0, 0, 0);

    // Stop during W_RUN ACCESS lets the write finish first
    xfer("dn r_tsr3", 8'h02, 0, 8'h00, 8'h00, 0, 0, 0);
    chk("dn quiet tick", {31'b0, tick}, 0);
    xfer("dn r_tsr4", 8'h02, 0, 8'h00, 8'h02, 0, 0, 0);
    chk("dn tick cnt3", {24'b0, tick_cnt}, 3);
    xfer("dn w_clr2", 8'h02, 1, 8'h00, 0, 0, 0, 0);
    xfer("dn w_ld3", 8'h01, 1, 8'hA3, 0, 0, 0, 0);
    xfer("dn w_run stop", 8'h01, 1, 8'h33, 0, 0, 0, 1);
    xfer("dn s_tcr", 8'h01, 1, 8'h00, 0, 0, 0, 0);
    xfer("dn s_tsr", 8'h02, 1, 8'h00, 0, 0, 0, 0);
    chk("dn stop busy", {31'b0, busy}, 0);

    // Slave error on W_RUN
    pulse_start(8'hF0, 1'b0, 2'b00);
    xfer("e w_tdr", 8'h00, 1, 8'hF0, 0, 0, 0, 0);
    xfer("e w_ld", 8'h01, 1, 8'h80, 0, 0, 0, 0);
    xfer("e w_run", 8'h01, 1, 8'h10, 0, 0, 1, 0);
    chk("slverr err", {31'b0, err}, 1);
    chk("slverr busy", {31'b0, busy}, 0);
    for (int i = 0; i < 5; i++) begin
      chk("slverr no psel", {31'b0, psel}, 0);
      @(negedge pclk);
    end
    pulse_start(8'hF0, 1'b0, 2'b00);
    chk("restart err clear", {31'b0, err}, 0);
    chk("restart busy", {31'b0, busy}, 1);
    xfer("r w_tdr", 8'h00, 1, 8'hF0, 0, 0, 0, 0);
    xfer("r w_ld", 8'h01, 1, 8'h80, 0, 0, 0, 0);
    xfer("r w_run", 8'h01, 1, 8'h10, 0, 0, 0, 0);

    // Expiries up to tick_cnt wrap
    for (int i = 0; i < 253; i++) begin
      xfer("wrap r_tsr", 8'h02, 0, 8'h00, 8'h01, 0, 0, 0);
      chk("wrap tick", {31'b0, tick}, 1);
      if (i == 251) chk("tick_cnt 0xFF", {24'b0, tick_cnt}, 32'hFF);
      if (i == 252) chk("tick_cnt wrap", {24'b0, tick_cnt}, 32'h00);
      xfer("wrap w_clr", 8'h02, 1, 8'h00, 0, 0, 0, 0);
      xfer("wrap w_ld", 8'h01, 1, 8'h80, 0, 0, 0, 0);
      xfer("wrap w_run", 8'h01, 1, 8'h10, 0, 0, 0, 0);
    end

    // Reset in the middle of an ACCESS cycle
    wait_setup("rst r_tsr");
    @(negedge pclk);
    chk("rst pre penable", {31'b0, penable}, 1);
    presetn = 1'b0;
    #1;
    chk("rst psel", {31'b0, psel}, 0);
    chk("rst penable", {31'b0, penable}, 0);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst paddr", {24'b0, paddr}, 0);
    chk("rst tick_cnt", {24'b0, tick_cnt}, 0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
